// File: rtl/dsm_ctrl_pkg.sv
// Shared definitions for the DSM DAC prescaler run controller:
// controller states, default reload value and default frame length.
package dsm_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      STOPPING = 2'd2
   } state_t;

   localparam int         DEFAULT_FRAME_LEN = 64;
   localparam logic [7:0] DEFAULT_PREVAL    = 8'd49;

endpackage

// File: rtl/frame_tick_counter.sv
// Wrap counter of prescaler ticks within a DSM frame (0..FRAME_LEN-1), flagging
// the second-to-last and last tick positions of the frame.
module frame_tick_counter #(
   parameter int FRAME_LEN = dsm_ctrl_pkg::DEFAULT_FRAME_LEN,
   parameter int CNT_W     = $clog2(FRAME_LEN)
) (
   input  logic clk50m,
   input  logic rst,
   input  logic clr,
   input  logic tick,
   output logic pre_last,
   output logic last
);

   localparam logic [CNT_W-1:0] LAST_CNT     = CNT_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] PRE_LAST_CNT = CNT_W'(FRAME_LEN - 2);

   logic [CNT_W-1:0] r_tick_cnt;

   always_ff @(posedge clk50m or posedge rst) begin
      if (rst) begin
         r_tick_cnt <= '0;
      end else if (clr) begin
         r_tick_cnt <= '0;
      end else if (tick) begin
         if (r_tick_cnt == LAST_CNT) begin
            r_tick_cnt <= '0;
         end else begin
            r_tick_cnt <= r_tick_cnt + CNT_W'(1);
         end
      end
   end

   assign pre_last = (r_tick_cnt == PRE_LAST_CNT);
   assign last     = (r_tick_cnt == LAST_CNT);

endmodule

// File: rtl/prescaler_frame_ctrl.sv
// Run controller for the DSM DAC prescaler: run/stop FSM, frame-aligned reload
// updates and one sample request per frame. Macro DSM_OVR_CNT_EN adds ovr_cnt.
module prescaler_frame_ctrl #(
   parameter int               PRE_W          = 8,
   parameter int               FRAME_LEN      = dsm_ctrl_pkg::DEFAULT_FRAME_LEN,
   parameter logic [PRE_W-1:0] DEFAULT_PREVAL = dsm_ctrl_pkg::DEFAULT_PREVAL
) (
   input  logic             clk50m,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             cfg_valid,
   input  logic [PRE_W-1:0] cfg_preval,
   output logic             cfg_ready,
   output logic             pre_en,
   output logic [PRE_W-1:0] pre_preval,
   input  logic             pre_cnt_zero,
   output logic             dsm_tick,
   output logic             frame_end,
   output logic             smp_req,
   input  logic             smp_ack,
   output logic             busy,
   output logic             overrun
`ifdef DSM_OVR_CNT_EN
   ,
   output logic [7:0]       ovr_cnt
`endif
);

   import dsm_ctrl_pkg::*;

   state_t           r_state;
   state_t           w_state_nxt;

   logic             w_tick;
   logic             w_pre_last;
   logic             w_last;
   logic             w_pre_tick;
   logic             w_frame_tick;
   logic             w_start_idle;
   logic             w_enter_idle;
   logic             w_cfg_accept;
   logic             w_ovr_evt;

   logic             r_pend_valid;
   logic             w_pend_valid_nxt;
   logic [PRE_W-1:0] r_pend;
   logic [PRE_W-1:0] w_pend_nxt;
   logic [PRE_W-1:0] r_pre_preval;
   logic [PRE_W-1:0] w_preval_nxt;

   logic             r_cfg_ready;
   logic             r_dsm_tick;
   logic             r_frame_end;
   logic             r_smp_req;
   logic             r_overrun;

   // Prescaler ticks only count while this block is enabling the prescaler.
   assign w_tick       = (r_state != IDLE) && pre_cnt_zero;
   assign w_pre_tick   = w_tick && w_pre_last;
   assign w_frame_tick = w_tick && w_last;
   assign w_start_idle = (r_state == IDLE) && start && !stop;
   assign w_enter_idle = (r_state == STOPPING) && (w_state_nxt == IDLE);
   assign w_cfg_accept = cfg_valid && r_cfg_ready;
   assign w_ovr_evt    = w_frame_tick && r_smp_req && !smp_ack;

   frame_tick_counter #(
      .FRAME_LEN (FRAME_LEN)
   ) u_frame_tick_counter (
      .clk50m   (clk50m),
      .rst      (rst),
      .clr      (w_start_idle),
      .tick     (w_tick),
      .pre_last (w_pre_last),
      .last     (w_last)
   );

   always_ff @(posedge clk50m or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (start && !stop) begin
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            if (stop) begin
               w_state_nxt = STOPPING;
            end
         end
         STOPPING: begin
            if (start && !stop) begin
               w_state_nxt = RUN;
            end else if (w_frame_tick) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Running: new values park in pending until the second-to-last tick, so the
   // prescaler picks them up at the frame-end reload and never mixes rates.
   always_comb begin
      w_pend_valid_nxt = r_pend_valid;
      w_pend_nxt       = r_pend;
      w_preval_nxt     = r_pre_preval;
      if (r_state == IDLE) begin
         w_pend_valid_nxt = 1'b0;
         if (w_cfg_accept) begin
            w_preval_nxt = cfg_preval;
         end else if (r_pend_valid) begin
            w_preval_nxt = r_pend;
         end
      end else begin
         if (r_pend_valid && (w_pre_tick || w_enter_idle)) begin
            w_preval_nxt     = r_pend;
            w_pend_valid_nxt = 1'b0;
         end
         if (w_cfg_accept) begin
            w_pend_nxt       = cfg_preval;
            w_pend_valid_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk50m or posedge rst) begin
      if (rst) begin
         r_pend_valid <= 1'b0;
         r_pend       <= '0;
         r_pre_preval <= DEFAULT_PREVAL;
         r_cfg_ready  <= 1'b0;
      end else begin
         r_pend_valid <= w_pend_valid_nxt;
         r_pend       <= w_pend_nxt;
         r_pre_preval <= w_preval_nxt;
         r_cfg_ready  <= (w_state_nxt == IDLE) || !w_pend_valid_nxt;
      end
   end

   // A frame end re-raises the request even when an ack lands in the same cycle.
   always_ff @(posedge clk50m or posedge rst) begin
      if (rst) begin
         r_dsm_tick  <= 1'b0;
         r_frame_end <= 1'b0;
         r_overrun   <= 1'b0;
         r_smp_req   <= 1'b0;
      end else begin
         r_dsm_tick  <= w_tick;
         r_frame_end <= w_frame_tick;
         r_overrun   <= w_ovr_evt;
         if (w_start_idle || w_frame_tick) begin
            r_smp_req <= 1'b1;
         end else if (smp_ack) begin
            r_smp_req <= 1'b0;
         end
      end
   end

`ifdef DSM_OVR_CNT_EN
   logic [7:0] r_ovr_cnt;

   always_ff @(posedge clk50m or posedge rst) begin
      if (rst) begin
         r_ovr_cnt <= 8'd0;
      end else if (w_start_idle) begin
         r_ovr_cnt <= 8'd0;
      end else if (w_ovr_evt && (r_ovr_cnt != 8'hFF)) begin
         r_ovr_cnt <= r_ovr_cnt + 8'd1;
      end
   end

   assign ovr_cnt = r_ovr_cnt;
`endif

   assign cfg_ready  = r_cfg_ready;
   assign pre_en     = (r_state != IDLE);
   assign busy       = (r_state != IDLE);
   assign pre_preval = r_pre_preval;
   assign dsm_tick   = r_dsm_tick;
   assign frame_end  = r_frame_end;
   assign smp_req    = r_smp_req;
   assign overrun    = r_overrun;

endmodule

// File: tb/tb_prescaler_frame_ctrl.sv
// Directed bench for prescaler_frame_ctrl with FRAME_LEN=4 driving a behavioural
// 8-bit down-counting prescaler (reset count 255, reload on zero, hold when disabled).
module tb_prescaler_frame_ctrl;

  logic       clk50m;
  logic       rst;
  logic       start;
  logic       stop;
  logic       cfg_valid;
  logic [7:0] cfg_preval;
  logic       cfg_ready;
  logic       pre_en;
  logic [7:0] pre_preval;
  logic       pre_cnt_zero;
  logic       dsm_tick;
  logic       frame_end;
  logic       smp_req;
  logic       smp_ack;
  logic       busy;
  logic       overrun;
`ifdef DSM_OVR_CNT_EN
  logic [7:0] ovr_cnt;
`endif

  int vectors;
  int miscompares;
  int cyc;
  int last_tick_cyc;
  int tick_per;
  int last_fe_cyc;
  int frame_per;
  int ovr_seen;
  int ack_age;
  int auto_ack;
  int n;

  // ---------------- clock / prescaler ----------------
  initial clk50m = 1'b0;
  always #5 clk50m = ~clk50m;

  logic [7:0] ps_cnt;
  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) ps_cnt <= 8'hFF;
    else if (pre_en) ps_cnt <= (ps_cnt == 8'd0) ? pre_preval : ps_cnt - 8'd1;
  end
  assign pre_cnt_zero = (ps_cnt == 8'd0);

  prescaler_frame_ctrl #(
    .PRE_W     (8),
    .FRAME_LEN (4)
  ) dut (
    .clk50m       (clk50m),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .cfg_valid    (cfg_valid),
    .cfg_preval   (cfg_preval),
    .cfg_ready    (cfg_ready),
    .pre_en       (pre_en),
    .pre_preval   (pre_preval),
    .pre_cnt_zero (pre_cnt_zero),
    .dsm_tick     (dsm_tick),
    .frame_end    (frame_end),
    .smp_req      (smp_req),
    .smp_ack      (smp_ack),
    .busy         (busy),
    .overrun      (overrun)
`ifdef DSM_OVR_CNT_EN
    ,
    .ovr_cnt      (ovr_cnt)
`endif
  );

  // ---------------- driver / monitor tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample 1 time unit after the edge, run the ack responder.
  task step();
    @(posedge clk50m);
    #1;
    cyc++;
    if (dsm_tick) begin
      tick_per = cyc - last_tick_cyc;
      last_tick_cyc = cyc;
    end
    if (frame_end) begin
      frame_per = cyc - last_fe_cyc;
      last_fe_cyc = cyc;
    end
    if (overrun) ovr_seen++;
    if (smp_ack) begin
      smp_ack = 1'b0;
      ack_age = 0;
    end else if (auto_ack != 0 && smp_req) begin
      ack_age++;
      if (ack_age >= 2) smp_ack = 1'b1;
    end else begin
      ack_age = 0;
    end
  endtask

  // sel: 0 = dsm_tick, 1 = frame_end, 2 = pre_cnt_zero
  task automatic wait_for(input int sel, input int max_cyc, input string tag, output int cnt);
    int found;
    found = 0;
    cnt = 0;
    while (found == 0 && cnt < max_cyc) begin
      step();
      cnt++;
      case (sel)
        0:       found = int'(dsm_tick);
        1:       found = int'(frame_end);
        default: found = int'(pre_cnt_zero);
      endcase
    end
    check(tag, found, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    vectors = 0; miscompares = 0; cyc = 0;
    last_tick_cyc = 0; tick_per = 0; last_fe_cyc = 0; frame_per = 0;
    ovr_seen = 0; ack_age = 0; auto_ack = 0;
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    cfg_valid = 1'b0; cfg_preval = 8'd0; smp_ack = 1'b0;

    // Reset values
    repeat (2) @(posedge clk50m);
    #1;
    check("rst_cfg_ready", cfg_ready, 0);
    check("rst_pre_en", pre_en, 0);
    check("rst_busy", busy, 0);
    check("rst_smp_req", smp_req, 0);
    check("rst_dsm_tick", dsm_tick, 0);
    check("rst_pre_preval", pre_preval, 49);
    rst = 1'b0;
    step();
    check("idle_cfg_ready", cfg_ready, 1);

    // stop in IDLE is ignored
    stop = 1'b1; step(); stop = 1'b0;
    check("idle_stop_busy", busy, 0);

    // Accept reload 4 in IDLE, then start
    cfg_valid = 1'b1; cfg_preval = 8'd4; step(); cfg_valid = 1'b0;
    check("idle_cfg_applied", pre_preval, 4);
    auto_ack = 1;
    start = 1'b1; step(); start = 1'b0;
    check("start_pre_en", pre_en, 1);
    check("start_busy", busy, 1);
    check("start_prefetch_req", smp_req, 1);
    wait_for(0, 300, "first_tick_seen", n);
    check("first_tick_latency", n, 256);
    wait_for(0, 20, "tick_seen", n);
    check("tick_period_4", tick_per, 5);
    wait_for(1, 40, "fe_seen", n);
    wait_for(1, 40, "fe_seen", n);
    check("frame_period_4", frame_per, 20);

    // Offer 9 mid-frame (tick_cnt=1): applied at tick_cnt=2, next frame at 10-cycle ticks
    wait_for(0, 20, "tick_seen", n);
    check("cfg_ready_before_offer", cfg_ready, 1);
    cfg_valid = 1'b1; cfg_preval = 8'd9; step(); cfg_valid = 1'b0;
    check("pending_cfg_ready", cfg_ready, 0);
    check("pending_preval_kept", pre_preval, 4);
    wait_for(0, 20, "tick_seen", n);
    check("pending_cfg_ready_t1", cfg_ready, 0);
    wait_for(0, 20, "tick_seen", n);
    check("applied_preval", pre_preval, 9);
    check("applied_cfg_ready", cfg_ready, 1);
    wait_for(1, 40, "fe_seen", n);
    check("offer_frame_period", frame_per, 20);
    check("offer_frame_last_tick", tick_per, 5);
    wait_for(0, 30, "tick_seen", n);
    check("tick_period_9", tick_per, 10);
    wait_for(1, 60, "fe_seen", n);
    check("frame_period_9", frame_per, 40);
    check("no_overrun_with_ack", ovr_seen, 0);

    // Withhold ack for two frames
    auto_ack = 0;
    wait_for(1, 60, "fe_seen", n);
    check("overrun_1_pulse", overrun, 1);
    check("overrun_1_req_held", smp_req, 1);
    wait_for(1, 60, "fe_seen", n);
    check("overrun_2_pulse", overrun, 1);
    check("overrun_count", ovr_seen, 2);
    check("overrun_2_req_held", smp_req, 1);
`ifdef DSM_OVR_CNT_EN
    check("ovr_cnt_2", ovr_cnt, 2);
`endif

    // Ack coinciding with the frame-end tick
    wait_for(0, 20, "tick_seen", n);
    wait_for(0, 20, "tick_seen", n);
    wait_for(0, 20, "tick_seen", n);
    wait_for(2, 20, "fe_tick_zero_seen", n);
    smp_ack = 1'b1;
    step();
    check("coinc_frame_end", frame_end, 1);
    check("coinc_no_overrun", overrun, 0);
    check("coinc_req_kept", smp_req, 1);
    step();
    check("coinc_req_kept_2", smp_req, 1);
    smp_ack = 1'b1; step();
    check("ack_clears_req", smp_req, 0);

    // stop at tick_cnt=1, run out the frame
    wait_for(0, 20, "tick_seen", n);
    stop = 1'b1; step(); stop = 1'b0;
    check("stopping_busy", busy, 1);
    check("stopping_pre_en", pre_en, 1);
    wait_for(1, 60, "stop_fe_seen", n);
    check("stopped_pre_en", pre_en, 0);
    check("stopped_busy", busy, 0);
    check("stopped_req_set", smp_req, 1);
    repeat (3) step();
    check("idle_req_held", smp_req, 1);
    check("idle_no_tick", dsm_tick, 0);

    // start during STOPPING cancels the stop
    auto_ack = 1;
    start = 1'b1; step(); start = 1'b0;
    check("restart_pre_en", pre_en, 1);
    wait_for(0, 20, "tick_seen", n);
    check("restart_first_tick", n, 10);
    wait_for(0, 20, "tick_seen", n);
    stop = 1'b1; step(); stop = 1'b0;
    check("cancel_stopping_busy", busy, 1);
    start = 1'b1; step(); start = 1'b0;
    wait_for(1, 60, "cancel_fe_seen", n);
    check("cancel_pre_en", pre_en, 1);
    check("cancel_busy", busy, 1);
    wait_for(0, 20, "tick_seen", n);
    check("cancel_tick_period", tick_per, 10);
    check("overrun_total", ovr_seen, 2);

    // Asynchronous reset mid-frame with a request outstanding
    wait_for(1, 60, "fe_seen", n);
    auto_ack = 0;
    wait_for(0, 20, "tick_seen", n);
    check("pre_rst_req", smp_req, 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_smp_req", smp_req, 0);
    check("arst_pre_en", pre_en, 0);
    check("arst_busy", busy, 0);
    check("arst_cfg_ready", cfg_ready, 0);
    check("arst_dsm_tick", dsm_tick, 0);
    check("arst_frame_end", frame_end, 0);
    check("arst_overrun", overrun, 0);
    check("arst_pre_preval", pre_preval, 49);
`ifdef DSM_OVR_CNT_EN
    check("arst_ovr_cnt", ovr_cnt, 0);
`endif
    @(posedge clk50m);
    #1;
    rst = 1'b0;
    step();
    check("post_rst_cfg_ready", cfg_ready, 1);
    check("post_rst_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
